// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // Stale-response counter width; wide enough for many back-to-back redirects
  // against a slow memory.
  localparam int unsigned DROP_W = 16;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of fetched instruction words; flush takes priority over push.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head_data,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path leaves one unassigned and no latch is inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-limited imem requests, in-order
// response queue and redirect flush. Define FETCH_BYPASS_EN for empty-queue response bypass.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = fetch_pkg::XLEN,
  parameter int unsigned      DEPTH    = 2,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned CRED_W = CNT_W + 1;

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   head_pc_q, head_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]  q_count;
  fetch_entry_t      q_head;
  fetch_entry_t      q_push_data;
  logic              q_push, q_pop, q_empty;

  logic [CRED_W-1:0] credits;
  logic [DROP_W-1:0] in_flight;
  logic [XLEN-1:0]   redirect_target;
  logic              req_hs, out_hs, rsp_live, byp_valid;

  assign credits         = CRED_W'(outstanding_q) + CRED_W'(q_count);
  assign in_flight       = drop_cnt_q + DROP_W'(outstanding_q);
  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign q_empty         = (q_count == '0);

  // A response is live only if no stale words are pending and a live request exists;
  // anything arriving in a redirect cycle belongs to the abandoned path.
  assign rsp_live = imem_rsp_valid && !redirect_valid
                 && (drop_cnt_q == '0) && (outstanding_q != '0);

  assign imem_req_valid = rst && !redirect_valid && (credits < CRED_W'(DEPTH));
  assign req_hs         = imem_req_valid && imem_req_ready;

`ifdef FETCH_BYPASS_EN
  assign byp_valid = rsp_live && q_empty;
  assign out_valid = rst && !redirect_valid && (!q_empty || byp_valid);
  assign out_instr = !out_valid ? NOP_INSTR
                   : (q_empty ? imem_rsp_data : q_head.instr);
`else
  assign byp_valid = 1'b0;
  assign out_valid = rst && !redirect_valid && !q_empty;
  assign out_instr = out_valid ? q_head.instr : NOP_INSTR;
`endif

  assign out_hs            = out_valid && out_ready;
  assign q_push            = rsp_live && !(byp_valid && out_ready);
  assign q_pop             = out_hs && !q_empty;
  assign q_push_data.instr = imem_rsp_data;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    head_pc_d     = head_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_target;
      head_pc_d     = redirect_target;
      outstanding_d = '0;
      // Every request still in flight becomes stale, minus one if it returns right now.
      drop_cnt_d    = in_flight - DROP_W'(imem_rsp_valid && (in_flight != '0));
    end else begin
      if (req_hs) begin
        fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
      end
      if (out_hs) begin
        head_pc_d = head_pc_q + XLEN'(INSTR_BYTES);
      end
      outstanding_d = outstanding_q + CNT_W'(req_hs) - CNT_W'(rsp_live);
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      head_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign imem_req_addr = fetch_pc_q;
  assign out_pc        = head_pc_q;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .head_data (q_head),
    .count     (q_count)
  );

`ifndef SYNTHESIS
  // A response with nothing in flight is a memory protocol violation.
  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> ((outstanding_q != '0) || (drop_cnt_q != '0)));

  a_queue_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    q_push |-> (q_count < CNT_W'(DEPTH)));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: epoch-tagged memory model plus a sequential-PC reference.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN     (64),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
  } mem_req_t;

  mem_req_t mem_q[$];

  // Stimulus knobs (percentages and latency range).
  int p_req_ready, lat_min, lat_max, p_out_ready, p_rsp, p_redirect;
  bit          rst_lvl;
  bit          dir_redirect;
  logic [63:0] dir_pc;

  // Reference state: the PC stream is sequential within an epoch; an epoch ends at every redirect.
  int          epoch;
  logic [63:0] m_fetch_pc, m_head_pc;
  int          m_credits;   // live requests accepted minus instructions delivered
  int          m_avail;     // live words returned before this cycle and not yet delivered
  int          cyc, since_rst, first_valid;
  int          n_checks, n_errors;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0003;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_knobs(input int rr, input int lmin, input int lmax,
                           input int orr, input int rs, input int rd);
    p_req_ready = rr; lat_min = lmin; lat_max = lmax;
    p_out_ready = orr; p_rsp = rs; p_redirect = rd;
  endtask

  // One clock cycle: drive inputs, compare outputs against the reference, then advance it.
  task automatic step();
    logic        redir, live_rsp, exp_req_valid, exp_out_valid;
    logic        req_hs_act, req_hs_exp, out_hs_exp, rsp_taken;
    logic [63:0] rpc, act_addr;
    mem_req_t    e;

    redir = rst_lvl && (dir_redirect || (int'($urandom_range(99)) < p_redirect));
    rpc   = dir_redirect ? dir_pc : {48'h0, 16'($urandom())};
    dir_redirect = 1'b0;

    rst            = rst_lvl;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = int'($urandom_range(99)) < p_req_ready;
    out_ready      = int'($urandom_range(99)) < p_out_ready;
    if (rst_lvl && mem_q.size() > 0 && mem_q[0].due <= cyc
        && int'($urandom_range(99)) < p_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
    #2;

    live_rsp      = imem_rsp_valid && !redir && (mem_q[0].epoch == epoch);
    exp_req_valid = rst_lvl && !redir && (m_credits < DEPTH);
    exp_out_valid = rst_lvl && !redir && ((m_avail > 0) || (BYP && live_rsp));

    check("req_valid", 64'(imem_req_valid), 64'(exp_req_valid));
    check("req_addr",  imem_req_addr, m_fetch_pc);
    check("out_valid", 64'(out_valid), 64'(exp_out_valid));
    check("out_pc",    out_pc, m_head_pc);
    check("out_instr", 64'(out_instr), 64'(exp_out_valid ? word_of(m_head_pc) : NOP_INSTR));

    if (rst_lvl && out_valid && first_valid < 0) first_valid = since_rst;

    req_hs_act = imem_req_valid && imem_req_ready;
    act_addr   = imem_req_addr;
    rsp_taken  = imem_rsp_valid;
    req_hs_exp = exp_req_valid && imem_req_ready;
    out_hs_exp = exp_out_valid && out_ready;

    @(posedge clk);
    #1;

    if (!rst_lvl) begin
      epoch++;
      m_fetch_pc = RESET_PC;
      m_head_pc  = RESET_PC;
      m_credits  = 0;
      m_avail    = 0;
      mem_q.delete();
      since_rst   = 0;
      first_valid = -1;
    end else begin
      if (rsp_taken) void'(mem_q.pop_front());
      if (req_hs_act) begin
        e.addr  = act_addr;
        e.epoch = epoch;
        e.due   = cyc + int'($urandom_range(lat_max, lat_min));
        mem_q.push_back(e);
      end
      if (redir) begin
        epoch++;
        m_fetch_pc = rpc & ~64'h3;
        m_head_pc  = rpc & ~64'h3;
        m_credits  = 0;
        m_avail    = 0;
      end else begin
        if (req_hs_exp) begin
          m_fetch_pc += 64'd4;
          m_credits++;
        end
        if (live_rsp) m_avail++;
        if (out_hs_exp) begin
          m_head_pc += 64'd4;
          m_credits--;
          m_avail--;
        end
      end
      since_rst++;
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
    n_checks = 0; n_errors = 0; cyc = 0; since_rst = 0; first_valid = -1; epoch = 0;
    m_fetch_pc = RESET_PC; m_head_pc = RESET_PC; m_credits = 0; m_avail = 0;
    dir_redirect = 1'b0; dir_pc = '0;
    set_knobs(100, 1, 1, 100, 100, 0);

    // Reset state.
    rst_lvl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    repeat (2) step();

    // Zero-wait memory, IF/ID always ready.
    rst_lvl = 1'b1;
    repeat (12) step();
    check("first_valid_cycle", 64'(first_valid), BYP ? 64'd1 : 64'd2);

    // IF/ID stall for 5 cycles, then release.
    set_knobs(100, 1, 1, 0, 100, 0);
    repeat (5) step();
    set_knobs(100, 1, 1, 100, 100, 0);
    repeat (8) step();

    // Memory not ready for 3 cycles.
    set_knobs(0, 1, 1, 100, 100, 0);
    repeat (3) step();
    set_knobs(100, 1, 1, 100, 100, 0);
    repeat (6) step();

    // Redirect with requests in flight at 3-cycle latency.
    set_knobs(100, 3, 3, 100, 100, 0);
    repeat (4) step();
    dir_redirect = 1'b1; dir_pc = 64'h100;
    step();
    repeat (14) step();

    // Back-to-back redirects with responses landing in both redirect cycles.
    set_knobs(100, 2, 2, 100, 100, 0);
    repeat (4) step();
    dir_redirect = 1'b1; dir_pc = 64'h200;
    step();
    dir_redirect = 1'b1; dir_pc = 64'h300;
    step();
    repeat (12) step();

    // Reset with the queue full and a request pending.
    set_knobs(100, 2, 2, 0, 100, 0);
    repeat (5) step();
    rst_lvl = 1'b0;
    step();
    rst_lvl = 1'b1;
    set_knobs(100, 1, 1, 100, 100, 0);
    repeat (10) step();
    check("first_valid_after_rst", 64'(first_valid), BYP ? 64'd1 : 64'd2);

    // Randomized traffic.
    repeat (15) begin
      set_knobs(int'($urandom_range(100, 20)), 1, int'($urandom_range(5, 1)),
                int'($urandom_range(100, 20)), int'($urandom_range(100, 40)),
                int'($urandom_range(8, 0)));
      repeat (100) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
